// File: rtl/enemy_turn_ctrl.sv
// enemy_turn_ctrl: sequences one enemy turn (RNG trigger, sample, legalise, issue) per player move
module enemy_turn_ctrl #(
  parameter logic [7:0] MAX_AMMO    = 8'd6,
  parameter logic [7:0] INIT_AMMO   = 8'd3,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       player_done,
  input  logic [1:0] rng,
  output logic       rng_trigger,
  output logic [7:0] ammo,
  output logic [7:0] tm,
  output logic [1:0] enemy_action,
  output logic       act_valid,
  input  logic       act_ready,
  output logic       busy,
  output logic       timeout
);
  localparam int IW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IW-1:0] TC = IW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, TRIG, SAMPLE, ISSUE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idle_cnt;
  logic pending, go, tc, hs;
  logic [1:0] legal;
  assign busy      = state != IDLE;
  assign act_valid = state == ISSUE;
  always_comb begin
    go      = state == IDLE && (player_done || pending);
    tc      = state == IDLE && TIMEOUT_CYC != 0 && idle_cnt == TC;
    hs      = state == ISSUE && act_ready;
    legal   = rng == 2'd3 ? 2'd2 :
              (rng == 2'd1 && ammo == 8'd0) ? 2'd0 :
              (rng == 2'd0 && ammo == MAX_AMMO) ? 2'd2 : rng;
    state_n = state == IDLE   ? ((go || tc) ? TRIG : IDLE) :
              state == TRIG   ? SAMPLE :
              state == SAMPLE ? ISSUE :
              hs              ? IDLE : ISSUE;
  end
  // trigger and timeout are registered so they come straight off flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ammo         <= INIT_AMMO;
      tm           <= 8'd0;
      idle_cnt     <= '0;
      pending      <= 1'b0;
      rng_trigger  <= 1'b0;
      timeout      <= 1'b0;
      enemy_action <= 2'd0;
    end else begin
      state       <= state_n;
      rng_trigger <= go || tc;
      timeout     <= tc && !go;
      idle_cnt    <= (state != IDLE || go || tc) ? '0 : (&idle_cnt ? idle_cnt : idle_cnt + 1'b1);
      pending     <= state == IDLE ? 1'b0 : (pending | player_done);
      if (state == SAMPLE) enemy_action <= legal;
      else if (hs) enemy_action <= 2'd0;
      if (hs) begin
        tm   <= tm + 8'd1;
        ammo <= enemy_action == 2'd1 ? ammo - 8'd1 : enemy_action == 2'd0 ? ammo + 8'd1 : ammo;
      end
    end
  end
endmodule

// File: tb/tb_enemy_turn_ctrl.sv
// tb_enemy_turn_ctrl: directed turns checked against a per-cycle turn model plus literal expectations
module tb_enemy_turn_ctrl;
  localparam int T = 10;
  logic clk = 0, reset = 0, player_done = 0, act_ready = 0, cmp_on = 0;
  logic [1:0] rng = 0;
  logic rng_trigger, act_valid, busy, timeout;
  logic [7:0] ammo, tm;
  logic [1:0] enemy_action;
  int ncmp = 0, nbad = 0;
  int m_age = -1, m_idle = 0, m_ammo = 3, m_tm = 0, m_act = 0;
  bit m_pend = 0, m_to = 0;

  enemy_turn_ctrl #(.MAX_AMMO(8'd6), .INIT_AMMO(8'd3), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .player_done(player_done), .rng(rng),
    .rng_trigger(rng_trigger), .ammo(ammo), .tm(tm), .enemy_action(enemy_action),
    .act_valid(act_valid), .act_ready(act_ready), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    ncmp++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int legal(input int r, input int a);
    if (r == 3) return 2;
    if (r == 1 && a == 0) return 0;
    if (r == 0 && a == 6) return 2;
    return r;
  endfunction

  // turn model: m_age counts cycles since the turn started, -1 while idle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age <= -1; m_idle <= 0; m_pend <= 0; m_to <= 0; m_ammo <= 3; m_tm <= 0; m_act <= 0;
    end else if (m_age < 0) begin
      if (player_done || m_pend) begin
        m_age <= 0; m_to <= 0; m_pend <= 0; m_idle <= 0;
      end else if (m_idle == T - 1) begin
        m_age <= 0; m_to <= 1; m_idle <= 0;
      end else m_idle <= m_idle + 1;
    end else begin
      m_pend <= m_pend | player_done;
      if (m_age == 1) m_act <= legal(int'(rng), m_ammo);
      if (m_age >= 2 && act_ready) begin
        m_age  <= -1;
        m_tm   <= (m_tm + 1) % 256;
        m_ammo <= m_ammo + (m_act == 0 ? 1 : m_act == 1 ? -1 : 0);
        m_act  <= 0;
      end else m_age <= m_age + 1;
    end
  end

  always @(negedge clk) if (cmp_on) begin
    chk("m_busy", int'(busy), int'(m_age >= 0));
    chk("m_trig", int'(rng_trigger), int'(m_age == 0));
    chk("m_timeout", int'(timeout), int'(m_age == 0 && m_to));
    chk("m_valid", int'(act_valid), int'(m_age >= 2));
    chk("m_action", int'(enemy_action), m_age >= 2 ? m_act : 0);
    chk("m_ammo", int'(ammo), m_ammo);
    chk("m_tm", int'(tm), m_tm);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // runs a turn with act_ready high in the first ISSUE cycle; via_pd=0 means we are already in TRIG
  task automatic do_turn(input logic [1:0] r, input int e_act, input bit via_pd);
    rng = r;
    if (via_pd) begin
      player_done = 1; step(); player_done = 0;
    end
    chk("trig", int'(rng_trigger), 1);
    step();
    chk("sample_trig", int'(rng_trigger), 0);
    chk("sample_valid", int'(act_valid), 0);
    step();
    chk("issue_valid", int'(act_valid), 1);
    chk("issue_action", int'(enemy_action), e_act);
    act_ready = 1; step(); act_ready = 0;
    chk("done_valid", int'(act_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    #1 cmp_on = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_ammo", int'(ammo), 3);
    chk("rst_tm", int'(tm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(act_valid), 0);
    chk("rst_trig", int'(rng_trigger), 0);
    // basic shoot turn
    do_turn(2'd1, 1, 1);
    chk("t2_ammo", int'(ammo), 2);
    chk("t2_tm", int'(tm), 1);
    // legalisation corners
    do_turn(2'd1, 1, 1);
    do_turn(2'd1, 1, 1);
    chk("t3_empty", int'(ammo), 0);
    do_turn(2'd1, 0, 1);
    chk("t3_ammo1", int'(ammo), 1);
    repeat (5) do_turn(2'd0, 0, 1);
    chk("t3_full", int'(ammo), 6);
    do_turn(2'd0, 2, 1);
    chk("t3_full_hold", int'(ammo), 6);
    do_turn(2'd3, 2, 1);
    chk("t3_tm", int'(tm), 11);
    // backpressure in ISSUE
    rng = 2'd1; player_done = 1; step(); player_done = 0;
    step(); step();
    repeat (5) begin
      chk("t4_valid", int'(act_valid), 1);
      chk("t4_action", int'(enemy_action), 1);
      chk("t4_ammo", int'(ammo), 6);
      chk("t4_tm", int'(tm), 11);
      step();
    end
    chk("t4_valid_last", int'(act_valid), 1);
    act_ready = 1; step(); act_ready = 0;
    chk("t4_ammo_after", int'(ammo), 5);
    chk("t4_tm_after", int'(tm), 12);
    chk("t4_valid_after", int'(act_valid), 0);
    // idle timeout
    repeat (9) step();
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_to", int'(timeout), 0);
    step();
    chk("t5_timeout", int'(timeout), 1);
    do_turn(2'd2, 2, 0);
    chk("t5_tm", int'(tm), 13);
    // player_done on the terminal count wins, no timeout
    repeat (9) step();
    player_done = 1; step(); player_done = 0;
    chk("t5_coinc_to", int'(timeout), 0);
    do_turn(2'd1, 1, 0);
    chk("t5_coinc_ammo", int'(ammo), 4);
    step(); chk("t5_no_extra1", int'(busy), 0);
    step(); chk("t5_no_extra2", int'(busy), 0);
    // two pulses while busy yield exactly one extra turn
    rng = 2'd2; player_done = 1; step(); player_done = 0;
    step(); step();
    player_done = 1; step(); player_done = 0;
    step();
    player_done = 1; step(); player_done = 0;
    act_ready = 1; step(); act_ready = 0;
    chk("t6_idle_busy", int'(busy), 0);
    step();
    chk("t6_pend_trig", int'(rng_trigger), 1);
    do_turn(2'd2, 2, 0);
    step(); chk("t6_one_extra1", int'(busy), 0);
    step(); chk("t6_one_extra2", int'(busy), 0);
    chk("t6_tm", int'(tm), 16);
    // turn counter wrap
    for (int i = m_tm; i < 255; i++) do_turn(2'd2, 2, 1);
    chk("t6_tm255", int'(tm), 255);
    do_turn(2'd2, 2, 1);
    chk("t6_tm_wrap", int'(tm), 0);
    // async reset in the middle of ISSUE
    rng = 2'd1; player_done = 1; step(); player_done = 0;
    step(); step();
    chk("t1_in_issue", int'(act_valid), 1);
    #2 reset = 1;
    #1;
    chk("t1_valid", int'(act_valid), 0);
    chk("t1_ammo", int'(ammo), 3);
    chk("t1_tm", int'(tm), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_trig", int'(rng_trigger), 0);
    chk("t1_timeout", int'(timeout), 0);
    chk("t1_action", int'(enemy_action), 0);
    @(posedge clk);
    #1 reset = 0;
    do_turn(2'd1, 1, 1);
    chk("t1_post_ammo", int'(ammo), 2);
    chk("t1_post_tm", int'(tm), 1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
